// File: rtl/adjacent_edge_scanner_if.sv
// -----------------------------------------------------------------------------
// adjacent_edge_scanner_if
// Groups the request and response signals of adjacent_edge_scanner.
//   start      : request, sampled only while the scanner is idle
//   xin / oin  : X / O occupancy, bit index = row*N + col
//   busy       : scanner is scanning or holding a result
//   move_valid : result available
//   move_ready : consumer accepts the result
//   move       : one-hot recommended move, or all-zero
//   found      : a template matched
//   err        : latched board had a cell claimed by both X and O
//   match_count: saturating count of accepted results with found = 1
//                (only when ADJ_EDGE_RELAX_EN is defined)
// Optional feature macro: ADJ_EDGE_RELAX_EN
// -----------------------------------------------------------------------------
interface adjacent_edge_scanner_if #(
  parameter int N     = 3,
  parameter int CTR_W = 8
);
  localparam int W = N * N;

  logic         start;
  logic [W-1:0] xin;
  logic [W-1:0] oin;
  logic         busy;
  logic         move_valid;
  logic         move_ready;
  logic [W-1:0] move;
  logic         found;
  logic         err;
`ifdef ADJ_EDGE_RELAX_EN
  logic [CTR_W-1:0] match_count;
`endif

  // Reject geometries the scanner cannot represent.
  if (N < 3 || (N % 2) == 0 || CTR_W < 1) begin : g_bad_param
    $error("adjacent_edge_scanner_if: N must be odd and >= 3, CTR_W >= 1");
  end

`ifdef ADJ_EDGE_RELAX_EN
  modport master (
    output start, xin, oin, move_ready,
    input  busy, move_valid, move, found, err, match_count
  );
  modport slave (
    input  start, xin, oin, move_ready,
    output busy, move_valid, move, found, err, match_count
  );
`else
  modport master (
    output start, xin, oin, move_ready,
    input  busy, move_valid, move, found, err
  );
  modport slave (
    input  start, xin, oin, move_ready,
    output busy, move_valid, move, found, err
  );
`endif
endinterface

// File: rtl/adjacent_edge_scanner.sv
// -----------------------------------------------------------------------------
// adjacent_edge_scanner
// On a start pulse latches an N x N board and evaluates the four rotations of
// the opposite-corner template (O in two opposite corners, X in the centre),
// one rotation per cycle. The first matching rotation supplies a one-hot edge
// move. The result is held under a valid/ready handshake.
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : adjacent_edge_scanner_if.slave (request, board, result)
// Optional feature macro: ADJ_EDGE_RELAX_EN
//   defined   -> only template and candidate cells are checked, and a
//                saturating match_count of accepted found results is kept
//   undefined -> strict matching, no counter
// -----------------------------------------------------------------------------
module adjacent_edge_scanner #(
  parameter int N     = 3,
  parameter int CTR_W = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  adjacent_edge_scanner_if.slave  bus
);
  localparam int W = N * N;
  localparam int C = (N - 1) / 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } state_e;

  // One-hot mask of cell (r,c).
  function automatic logic [W-1:0] cell_f(input int r, input int c);
    return {{(W-1){1'b0}}, 1'b1} << (r * N + c);
  endfunction

  // O cells of rotation k: even rotations use the main diagonal corners.
  function automatic logic [W-1:0] o_mask_f(input int k);
    if ((k % 2) == 0) begin
      return cell_f(0, 0) | cell_f(N - 1, N - 1);
    end else begin
      return cell_f(0, N - 1) | cell_f(N - 1, 0);
    end
  endfunction

  // Candidate edge cell of rotation k, (C,0) turned clockwise k times.
  function automatic logic [W-1:0] cand_f(input int k);
    case (k)
      0:       return cell_f(C, 0);
      1:       return cell_f(0, C);
      2:       return cell_f(C, N - 1);
      default: return cell_f(N - 1, C);
    endcase
  endfunction

  localparam logic [W-1:0] X_MASK = cell_f(C, C);

  if (N < 3 || (N % 2) == 0 || CTR_W < 1) begin : g_bad_param
    $error("adjacent_edge_scanner: N must be odd and >= 3, CTR_W >= 1");
  end

  state_e       state_q, state_d;
  logic [1:0]   rot_q, rot_d;
  logic [W-1:0] xl_q, xl_d;
  logic [W-1:0] ol_q, ol_d;
  logic         hit_q, hit_d;
  logic [W-1:0] cand_q, cand_d;
  logic         busy_q, busy_d;
  logic         valid_q, valid_d;
  logic [W-1:0] move_q, move_d;
  logic         found_q, found_d;
  logic         err_q, err_d;
`ifdef ADJ_EDGE_RELAX_EN
  logic [CTR_W-1:0] count_q, count_d;
`endif

  logic [3:0]   match_s;
  logic [W-1:0] cand_mask_s [4];

  // Per-rotation template match on the latched boards.
  for (genvar k = 0; k < 4; k++) begin : g_rot
    localparam logic [W-1:0] O_M = o_mask_f(k);
    localparam logic [W-1:0] C_M = cand_f(k);
    assign cand_mask_s[k] = C_M;
`ifdef ADJ_EDGE_RELAX_EN
    assign match_s[k] = ((xl_q & X_MASK) == X_MASK) &&
                        ((ol_q & O_M) == O_M) &&
                        (((xl_q | ol_q) & C_M) == {W{1'b0}});
`else
    // Exact equality also enforces every non-template cell (including the
    // candidate) being empty in both boards.
    assign match_s[k] = (xl_q == X_MASK) && (ol_q == O_M);
`endif
  end

  // Next-state and next-output logic for the scan/handshake FSM.
  always_comb begin
    state_d = state_q;
    rot_d   = rot_q;
    xl_d    = xl_q;
    ol_d    = ol_q;
    hit_d   = hit_q;
    cand_d  = cand_q;
    valid_d = valid_q;
    move_d  = move_q;
    found_d = found_q;
    err_d   = err_q;
`ifdef ADJ_EDGE_RELAX_EN
    count_d = count_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SCAN;
          rot_d   = 2'd0;
          xl_d    = bus.xin;
          ol_d    = bus.oin;
          hit_d   = 1'b0;
          cand_d  = {W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        // Only the first matching rotation is recorded.
        if (!hit_q && match_s[rot_q]) begin
          hit_d  = 1'b1;
          cand_d = cand_mask_s[rot_q];
        end else begin
          hit_d  = hit_q;
        end
        if (rot_q == 2'd3) begin
          state_d = RESP;
          rot_d   = 2'd0;
          valid_d = 1'b1;
          err_d   = |(xl_q & ol_q);
          found_d = hit_d & ~err_d;
          move_d  = found_d ? cand_d : {W{1'b0}};
        end else begin
          rot_d   = rot_q + 2'd1;
        end
      end
      RESP: begin
        if (bus.move_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
          move_d  = {W{1'b0}};
          found_d = 1'b0;
          err_d   = 1'b0;
`ifdef ADJ_EDGE_RELAX_EN
          if (found_q && (count_q != {CTR_W{1'b1}})) begin
            count_d = count_q + {{(CTR_W-1){1'b0}}, 1'b1};
          end else begin
            count_d = count_q;
          end
`endif
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        move_d  = {W{1'b0}};
        found_d = 1'b0;
        err_d   = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rot_q   <= 2'd0;
      xl_q    <= {W{1'b0}};
      ol_q    <= {W{1'b0}};
      hit_q   <= 1'b0;
      cand_q  <= {W{1'b0}};
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      move_q  <= {W{1'b0}};
      found_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef ADJ_EDGE_RELAX_EN
      count_q <= {CTR_W{1'b0}};
`endif
    end else begin
      state_q <= state_d;
      rot_q   <= rot_d;
      xl_q    <= xl_d;
      ol_q    <= ol_d;
      hit_q   <= hit_d;
      cand_q  <= cand_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      move_q  <= move_d;
      found_q <= found_d;
      err_q   <= err_d;
`ifdef ADJ_EDGE_RELAX_EN
      count_q <= count_d;
`endif
    end
  end

  assign bus.busy       = busy_q;
  assign bus.move_valid = valid_q;
  assign bus.move       = move_q;
  assign bus.found      = found_q;
  assign bus.err        = err_q;
`ifdef ADJ_EDGE_RELAX_EN
  assign bus.match_count = count_q;
`endif

endmodule
